// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline types and constants used by the write-back stage.
//   wb_req_t : one pending register-file write (destination + data)
//   REG_NUM  : architectural register count
//   SRC_*    : producer slot numbers (ALU, LSU load data, MUL/DIV)
// ----------------------------------------------------------------------------
package pipeline_pkg;

    localparam int REG_NUM = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter.sv
// ----------------------------------------------------------------------------
// wb_arbiter
// Picks one requesting slot per cycle and returns a one-hot grant.
//
// Build option: WB_ROUND_ROBIN_EN
//   defined   : round-robin. The search starts at the slot after the last
//               granted one (mod NSRC); the pointer moves only on a grant.
//               clk/rstn ports exist only in this build.
//   undefined : fixed priority, highest slot index wins (src2 > src1 > src0).
//
// Ports:
//   clk, rstn : clock / async active-low reset (round-robin build only)
//   i_req     : NSRC request vector (slot full)
//   o_gnt     : NSRC one-hot grant, all zero when nothing requests
// ----------------------------------------------------------------------------
module wb_arbiter #(
    parameter int NSRC = 3
) (
`ifdef WB_ROUND_ROBIN_EN
    input  logic            clk,
    input  logic            rstn,
`endif
    input  logic [NSRC-1:0] i_req,
    output logic [NSRC-1:0] o_gnt
);

`ifdef WB_ROUND_ROBIN_EN
    localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gnt_idx;
    logic             w_found;

    // Rotate the search so the slot after the last winner is looked at first.
    always_comb begin
        o_gnt     = '0;
        w_gnt_idx = r_ptr;
        w_found   = 1'b0;
        for (int i = 1; i <= NSRC; i++) begin
            if (!w_found && i_req[(int'(r_ptr) + i) % NSRC]) begin
                o_gnt[(int'(r_ptr) + i) % NSRC] = 1'b1;
                w_gnt_idx = PTR_W'((int'(r_ptr) + i) % NSRC);
                w_found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_gnt_idx;
        end
    end
`else
    logic w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (!w_found && i_req[i]) begin
                o_gnt[i] = 1'b1;
                w_found  = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// ----------------------------------------------------------------------------
// regfile_writeback
// Write side of the 32x32 register file. Buffers one result per producer,
// commits one write per cycle, and keeps a per-register pending-write count
// that decode uses for RAW stalls.
//
// Build option: WB_ROUND_ROBIN_EN selects round-robin arbitration between
// producers; otherwise fixed priority src2 > src1 > src0 (see wb_arbiter).
//
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   iss_valid  : decode issues an instruction writing iss_rd
//   iss_rd     : destination of the issuing instruction
//   iss_ready  : low while iss_rd's pending counter is saturated
//   src_valid  : per-producer result valid     (NSRC)
//   src_ready  : per-producer slot can accept  (NSRC)
//   src_rd     : per-producer destination      (NSRC*5)
//   src_data   : per-producer result           (NSRC*32)
//   we         : regfile write enable (one-cycle registered pulse)
//   rd_index   : regfile write index
//   rd_write   : regfile write data
//   busy       : bit r set while register r has a pending write
//
// Handshake: a slot loads on src_valid & src_ready; a producer holds rd/data
// stable while valid is high and ready is low. A slot granted this cycle
// reports ready, so it can be refilled on the same edge it drains.
// ----------------------------------------------------------------------------
module regfile_writeback
    import pipeline_pkg::*;
#(
    parameter int NSRC  = 3,
    parameter int CNT_W = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    output logic              iss_ready,
    input  logic [NSRC-1:0]   src_valid,
    output logic [NSRC-1:0]   src_ready,
    input  logic [NSRC*5-1:0] src_rd,
    input  logic [NSRC*32-1:0] src_data,
    output logic              we,
    output logic [4:0]        rd_index,
    output logic [31:0]       rd_write,
    output logic [31:0]       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ---------------- producer slots ----------------
    wb_req_t          r_slot [NSRC];
    logic [NSRC-1:0]  r_full;
    logic [NSRC-1:0]  w_gnt;
    logic [NSRC-1:0]  w_load;
    wb_req_t          w_gnt_req;

    assign src_ready = ~r_full | w_gnt;
    assign w_load    = src_valid & src_ready;

    wb_arbiter #(
        .NSRC (NSRC)
    ) u_arb (
`ifdef WB_ROUND_ROBIN_EN
        .clk   (clk),
        .rstn  (rstn),
`endif
        .i_req (r_full),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full <= '0;
            for (int s = 0; s < NSRC; s++) begin
                r_slot[s] <= '0;
            end
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                if (w_load[s]) begin
                    r_full[s]      <= 1'b1;
                    r_slot[s].rd   <= src_rd[s*5 +: 5];
                    r_slot[s].data <= src_data[s*32 +: 32];
                end else if (w_gnt[s]) begin
                    r_full[s] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_gnt_req = '0;
        for (int s = 0; s < NSRC; s++) begin
            if (w_gnt[s]) begin
                w_gnt_req = r_slot[s];
            end
        end
    end

    // ---------------- registered write port ----------------
    logic        r_we;
    logic [4:0]  r_rd_index;
    logic [31:0] r_rd_write;

    // r0 results still win arbitration and drain their slot; only the write
    // strobe is suppressed. Index/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_we       <= 1'b0;
            r_rd_index <= '0;
            r_rd_write <= '0;
        end else if (|w_gnt) begin
            r_we       <= (w_gnt_req.rd != 5'd0);
            r_rd_index <= w_gnt_req.rd;
            r_rd_write <= w_gnt_req.data;
        end else begin
            r_we       <= 1'b0;
        end
    end

    assign we       = r_we;
    assign rd_index = r_rd_index;
    assign rd_write = r_rd_write;

    // ---------------- pending-write scoreboard ----------------
    logic [CNT_W-1:0]   r_cnt [REG_NUM];
    logic [REG_NUM-1:0] w_inc;
    logic [REG_NUM-1:0] w_dec;
    logic [REG_NUM-1:0] w_busy;

    // A commit to iss_rd in this cycle frees a count, so a saturated
    // register can still accept an issue (net count unchanged).
    assign iss_ready = (r_cnt[iss_rd] != CNT_MAX) | (r_we && (r_rd_index == iss_rd));

    always_comb begin
        w_inc  = '0;
        w_dec  = '0;
        w_busy = '0;
        for (int r = 1; r < REG_NUM; r++) begin
            w_inc[r]  = iss_valid && iss_ready && (iss_rd == 5'(r));
            w_dec[r]  = r_we && (r_rd_index == 5'(r));
            w_busy[r] = (r_cnt[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < REG_NUM; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 1; r < REG_NUM; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_cnt[r] <= r_cnt[r] + CNT_ONE;
                end else if (w_dec[r] && !w_inc[r] && (r_cnt[r] != '0)) begin
                    r_cnt[r] <= r_cnt[r] - CNT_ONE;
                end
            end
        end
    end

    assign busy = w_busy;

`ifndef SYNTHESIS
    // A commit must always match an earlier issue.
    a_no_underflow : assert property (
        @(posedge clk) disable iff (!rstn)
        !(r_we && (r_rd_index != 5'd0) && (r_cnt[r_rd_index] == '0))
    );
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
    import pipeline_pkg::*;

    localparam int NSRC  = 3;
    localparam int CNT_W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    logic              iss_valid;
    logic [4:0]        iss_rd;
    logic              iss_ready;
    logic [NSRC-1:0]   src_valid;
    logic [NSRC-1:0]   src_ready;
    logic [NSRC*5-1:0] src_rd;
    logic [NSRC*32-1:0] src_data;
    logic              we;
    logic [4:0]        rd_index;
    logic [31:0]       rd_write;
    logic [31:0]       busy;

    regfile_writeback #(
        .NSRC  (NSRC),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_rd    (src_rd),
        .src_data  (src_data),
        .we        (we),
        .rd_index  (rd_index),
        .rd_write  (rd_write),
        .busy      (busy)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] exp_q[$];   // {rd, data} in expected commit order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_check();
        logic [36:0] e;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_we: got rd=%0d data=0x%08h expected no write", rd_index, rd_write);
            end else begin
                e = exp_q.pop_front();
                check("commit_rd", 32'(rd_index), 32'(e[36:32]));
                check("commit_data", rd_write, e[31:0]);
            end
        end
    endtask

    // Advance one cycle; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        sb_check();
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_src(input int s, input logic [4:0] rd, input logic [31:0] d);
        src_valid[s]       = 1'b1;
        src_rd[s*5 +: 5]   = rd;
        src_data[s*32 +: 32] = d;
    endtask

    task automatic issue(input logic [4:0] rd);
        iss_valid = 1'b1;
        iss_rd    = rd;
        #1;
        check("iss_ready_on_issue", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [4:0]  rd;
        int          src;
        logic [31:0] data;
        logic        exp_we;
    } vec_t;

    vec_t vecs[4];

    logic [2:0] rdy_pat[3];

    initial begin
        vecs[0] = '{rd: 5'd7,  src: SRC_ALU, data: 32'hDEADBEEF, exp_we: 1'b1};
        vecs[1] = '{rd: 5'd0,  src: SRC_LSU, data: 32'h00001234, exp_we: 1'b0};
        vecs[2] = '{rd: 5'd31, src: SRC_LSU, data: 32'hA5A55A5A, exp_we: 1'b1};
        vecs[3] = '{rd: 5'd15, src: SRC_MDU, data: 32'h0F0F1234, exp_we: 1'b1};

        iss_valid = 1'b0;
        iss_rd    = '0;
        src_valid = '0;
        src_rd    = '0;
        src_data  = '0;

        // Reset and reset state.
        #1 rstn = 1'b0;
        #10;
        check("rst_we", 32'(we), 32'd0);
        check("rst_rd_index", 32'(rd_index), 32'd0);
        check("rst_rd_write", rd_write, 32'd0);
        check("rst_busy", busy, 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'h7);
        check("rst_iss_ready", 32'(iss_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Single writes, one producer at a time (includes an r0 result).
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].rd != 5'd0) begin
                issue(vecs[i].rd);
            end
            set_src(vecs[i].src, vecs[i].rd, vecs[i].data);
            #1;
            check("vec_src_ready", 32'(src_ready[vecs[i].src]), 32'd1);
            check("vec_busy_pending", 32'(busy[vecs[i].rd]), 32'(vecs[i].rd != 5'd0));
            if (vecs[i].exp_we) exp_q.push_back({vecs[i].rd, vecs[i].data});
            tick();
            src_valid = '0;
            tick();
            check("vec_we_pulse", 32'(we), 32'(vecs[i].exp_we));
            check("vec_busy0", 32'(busy[0]), 32'd0);
            tick();
            check("vec_we_drop", 32'(we), 32'd0);
            check("vec_busy_clear", 32'(busy[vecs[i].rd]), 32'd0);
        end

        // Contention: all three producers in one cycle. Last grant was src2.
        issue(5'd1);
        issue(5'd2);
        issue(5'd3);
        set_src(0, 5'd1, 32'hC0000001);
        set_src(1, 5'd2, 32'hC0000002);
        set_src(2, 5'd3, 32'hC0000003);
`ifdef WB_ROUND_ROBIN_EN
        exp_q.push_back({5'd1, 32'hC0000001});
        exp_q.push_back({5'd2, 32'hC0000002});
        exp_q.push_back({5'd3, 32'hC0000003});
        rdy_pat[0] = 3'b001;
        rdy_pat[1] = 3'b011;
        rdy_pat[2] = 3'b111;
`else
        exp_q.push_back({5'd3, 32'hC0000003});
        exp_q.push_back({5'd2, 32'hC0000002});
        exp_q.push_back({5'd1, 32'hC0000001});
        rdy_pat[0] = 3'b100;
        rdy_pat[1] = 3'b110;
        rdy_pat[2] = 3'b111;
`endif
        tick();
        src_valid = '0;
        #1;
        check("cont_ready0", 32'(src_ready), 32'(rdy_pat[0]));
        tick();
        check("cont_ready1", 32'(src_ready), 32'(rdy_pat[1]));
        tick();
        check("cont_ready2", 32'(src_ready), 32'(rdy_pat[2]));
        tick();
        tick();
        check("cont_busy_clear", 32'(busy[3:1]), 32'd0);

        // Back-to-back refill of src0.
        for (int i = 0; i < 4; i++) issue(5'(10 + i));
        for (int i = 0; i < 4; i++) begin
            set_src(0, 5'(10 + i), 32'hB0B00000 + 32'(i));
            #1;
            check("b2b_src0_ready", 32'(src_ready[0]), 32'd1);
            exp_q.push_back({5'(10 + i), 32'hB0B00000 + 32'(i)});
            tick();
            if (i > 0) check("b2b_we", 32'(we), 32'd1);
        end
        src_valid = '0;
        tick();
        check("b2b_we_last", 32'(we), 32'd1);
        tick();
        check("b2b_we_end", 32'(we), 32'd0);
        check("b2b_busy_clear", 32'(busy[13:10]), 32'd0);

        // Saturation of r9, then commit in the same cycle as a 4th issue.
        issue(5'd9);
        issue(5'd9);
        issue(5'd9);
        iss_rd = 5'd9;
        #1;
        check("sat_iss_ready_low", 32'(iss_ready), 32'd0);
        check("sat_busy9", 32'(busy[9]), 32'd1);
        set_src(0, 5'd9, 32'h99999999);
        exp_q.push_back({5'd9, 32'h99999999});
        tick();
        src_valid = '0;
        tick();
        check("sat_commit_we", 32'(we), 32'd1);
        iss_valid = 1'b1;
        iss_rd    = 5'd9;
        #1;
        check("sat_iss_ready_commit", 32'(iss_ready), 32'd1);
        tick();
        iss_valid = 1'b0;
        #1;
        check("sat_cnt_held", 32'(iss_ready), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of activity.
        issue(5'd5);
        issue(5'd5);
        set_src(0, 5'd5, 32'h5555AAAA);
        set_src(1, 5'd5, 32'h5555AAAA);
        set_src(2, 5'd5, 32'h5555AAAA);
        exp_q.push_back({5'd5, 32'h5555AAAA});
        tick();
        src_valid = '0;
        tick();
        check("mid_we_before", 32'(we), 32'd1);
        check("mid_busy5_before", 32'(busy[5]), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_we", 32'(we), 32'd0);
        check("mid_rst_busy", busy, 32'd0);
        check("mid_rst_src_ready", 32'(src_ready), 32'h7);
        check("mid_rst_rd_write", rd_write, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("post_rst_we", 32'(we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side companion of the 32x32 register file; sole driver of its single write port (we, rd_index, rd_write).
- Collects results from NSRC producers: src0 = ALU, src1 = LSU load data, src2 = MUL/DIV.
- Each producer has one holding slot. One write is committed per cycle.
- Keeps a per-register pending-write scoreboard that decode uses for RAW hazard stalls.

Parameters:
- NSRC, 3, number of result producers.
- CNT_W, 2, width of each register's pending-write counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  5  destination of the issuing instruction.
- iss_ready  out  1  low when iss_rd's pending counter is saturated.
- src_valid  in  NSRC  per-producer result valid.
- src_ready  out  NSRC  per-producer slot free.
- src_rd  in  NSRC*5  per-producer destination index.
- src_data  in  NSRC*32  per-producer result.
- we  out  1  regfile write enable.
- rd_index  out  5  regfile write index.
- rd_write  out  32  regfile write data.
- busy  out  32  bit i set while reg i has a pending write.

Behaviour:
- Reset (rstn low, asynchronous):
  - all slots empty; src_ready all 1
  - we=0, rd_index=0, rd_write=0
  - all counters 0; busy=0
  - arbiter pointer = 0
- Slot handshake:
  - Slot s loads when src_valid[s] & src_ready[s].
  - src_ready[s] = slot empty OR slot granted this cycle (same-cycle refill allowed).
  - A producer holds rd and data stable while valid and not ready.
- Arbitration:
  - Every cycle, choose one full slot (policy under Optional Feature).
  - The grant registers we=1, rd_index, rd_write on the next clk edge; the slot frees on that same edge.
  - Latency from slot load to we is at least 1 cycle. we and its data are a registered pulse held for exactly one cycle per grant.
  - No full slot: we=0 next cycle; rd_index and rd_write hold their old values.
- r0:
  - Results with rd=0 are accepted and granted normally, but the registered we is forced to 0.
  - iss_rd=0 never touches a counter.
  - busy[0] is always 0.
- Scoreboard:
  - cnt[r] increments on iss_valid & iss_ready & iss_rd=r.
  - cnt[r] decrements when the registered write commits (we=1, rd_index=r).
  - Increment and decrement on the same r in the same cycle: net unchanged.
  - iss_ready = (cnt[iss_rd] != 2^CNT_W-1) OR (decrement of iss_rd this cycle).
  - busy[r] = (cnt[r] != 0).
- Underflow: a commit to a register whose cnt is 0 leaves it at 0. Simulation assertion error.
- Ordering:
  - Writes to the same rd from different producers commit in grant order.
  - Software (the pipeline) guarantees program order through the scoreboard. This block does not reorder.
- Forwarding: the regfile forwards rd_write on its read ports during the cycle we is high. This block adds no extra bypass.

Optional Feature:
- Macro: WB_ROUND_ROBIN_EN.
- Defined: round-robin grant.
  - Search starts at the slot after the last granted slot, wrapping modulo NSRC.
  - The pointer updates only on a grant.
  - Any full slot is granted within NSRC cycles.
- Undefined: fixed priority, src2 > src1 > src0.
  - Pointer logic removed.
  - Starvation of src0 is accepted.

Decomposition:
- Shared package pipeline_pkg:
  - typedef wb_req_t {logic [4:0] rd; logic [31:0] data;}
  - localparam REG_NUM=32
  - localparam SRC_ALU=0, SRC_LSU=1, SRC_MDU=2
- Sub-module wb_arbiter: NSRC request vector in, one-hot grant out. Contains the pointer and the ifdef.
- Scoreboard counters stay inline.

Test Plan:
- Reset mid-operation:
  - Stimulus: slots full, cnt[5]=2, assert rstn=0 asynchronously without a clock edge.
  - Response: we=0, busy=0, src_ready all 1 immediately.
- Single write:
  - Stimulus: issue rd=7; next cycle src0 valid rd=7 data=0xDEADBEEF.
  - Response: busy[7]=1. One cycle later we=1, rd_index=7, rd_write=0xDEADBEEF. Following cycle busy[7]=0.
- Contention:
  - Stimulus: all three sources valid in the same cycle (rd=1,2,3).
  - RR response: commits 1,2,3 on consecutive cycles.
  - Fixed-priority response: commits 3,2,1.
  - Both: src_ready deasserts only for waiting slots.
- Saturation:
  - Stimulus: issue rd=9 three times with no commits.
  - Response: iss_ready=0 for rd=9.
  - Stimulus: commit rd=9 in the same cycle as a fourth issue.
  - Response: iss_ready=1, cnt stays 3.
- r0:
  - Stimulus: src1 valid rd=0 data=0x1234.
  - Response: accepted, we stays 0, busy[0]=0.
- Back-to-back refill:
  - Stimulus: src0 valid on 4 consecutive cycles, rd=10..13, other sources idle.
  - Response: we high 4 consecutive cycles with rd 10..13, src0_ready constantly 1.
